// File: rtl/dual_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : dual_input_debouncer
//  Description : Two-channel input conditioner for the a/b inputs of the
//                downstream 2-input AND gate stage. Each raw asynchronous
//                input passes through a SYNC_STAGES-deep synchronizer and a
//                four-state debounce FSM. The gate only sees levels that
//                have been held for DEBOUNCE_CYCLES consecutive samples.
//
//  Parameters  : SYNC_STAGES      synchronizer depth per channel (>= 2)
//                DEBOUNCE_CYCLES  equal samples needed to accept a level (>= 2)
//                CNT_W            derived counter width, leave at default
//
//  Ports       : clk     in   single clock, rising edge
//                rst_n   in   asynchronous active-low reset
//                a_raw   in   raw asynchronous input, channel A
//                b_raw   in   raw asynchronous input, channel B
//                a       out  debounced channel A level
//                b       out  debounced channel B level
//                busy    out  registered: either channel in a CHECK state
//                a_rise  out  1-clk pulse when a goes 0->1 (DEBOUNCE_EDGE_EN)
//                b_rise  out  1-clk pulse when b goes 0->1 (DEBOUNCE_EDGE_EN)
//
//  Build macro : DEBOUNCE_EDGE_EN - adds the a_rise/b_rise outputs.
//
//  Revision    : 1.0  initial release
// ============================================================================
module dual_input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic busy
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic a_rise,
    output logic b_rise
`endif
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    // Count value at which a candidate level is accepted.
    localparam logic [CNT_W-1:0] c_cnt_target = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0] w_raw;
    logic [1:0] w_out;
    logic [1:0] w_check_nxt;
`ifdef DEBOUNCE_EDGE_EN
    logic [1:0] w_rise_nxt;
    logic [1:0] r_rise;
`endif
    logic       r_busy;

    assign w_raw = {b_raw, a_raw};

    // ------------------------------------------------------------------------
    // Per-channel synchronizer, debounce FSM and counter (bit 0 = A, 1 = B)
    // ------------------------------------------------------------------------
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic [CNT_W-1:0]       w_cnt_inc;
        logic                   r_out;
        logic                   w_out_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[ch]};
            end
        end

        assign w_s       = r_sync[SYNC_STAGES-1];
        assign w_cnt_inc = r_cnt + CNT_W'(1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= STABLE_LO;
                r_cnt   <= '0;
                r_out   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= w_out_nxt;
            end
        end

        // The output only moves on entry to a STABLE state, so a bounce that
        // aborts a CHECK leaves it untouched and the gate never sees a glitch.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_out_nxt   = r_out;
            case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        w_state_nxt = CHECK_HI;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                CHECK_HI: begin
                    if (w_s) begin
                        if (w_cnt_inc == c_cnt_target) begin
                            w_state_nxt = STABLE_HI;
                            w_out_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = STABLE_LO;
                        w_cnt_nxt   = '0;
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        w_state_nxt = CHECK_LO;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                CHECK_LO: begin
                    if (!w_s) begin
                        if (w_cnt_inc == c_cnt_target) begin
                            w_state_nxt = STABLE_LO;
                            w_out_nxt   = 1'b0;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = STABLE_HI;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                end
            endcase
        end

        assign w_out[ch]       = r_out;
        // busy is registered from the next state so it moves with the FSM.
        assign w_check_nxt[ch] = (w_state_nxt == CHECK_HI) || (w_state_nxt == CHECK_LO);
`ifdef DEBOUNCE_EDGE_EN
        assign w_rise_nxt[ch]  = (r_state == CHECK_HI) && (w_state_nxt == STABLE_HI);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_check_nxt;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
        end else begin
            r_rise <= w_rise_nxt;
        end
    end

    assign a_rise = r_rise[0];
    assign b_rise = r_rise[1];
`endif

    assign a    = w_out[0];
    assign b    = w_out[1];
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dual_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_input_debouncer
//  Description : Directed self-checking bench for dual_input_debouncer with
//                SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (latency 5 edges).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic busy;
`ifdef DEBOUNCE_EDGE_EN
    logic a_rise;
    logic b_rise;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Run-length reference for channel A: the accepted level flips once DEB
    // consecutive synchronized samples differ from it.
    logic [SYNC-1:0] m_pipe;
    logic            m_out;
    int              m_run;

    always #5 clk = ~clk;

    dual_input_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a      (a),
        .b      (b),
`ifdef DEBOUNCE_EDGE_EN
        .a_rise (a_rise),
        .b_rise (b_rise),
`endif
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe = '0;
        m_out  = 1'b0;
        m_run  = 0;
    endtask

    task automatic model_step();
        logic s;
        s = m_pipe[SYNC-1];
        if (s != m_out) begin
            m_run++;
            if (m_run == DEB) begin
                m_out = s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_pipe = {m_pipe[SYNC-2:0], a_raw};
    endtask

    // Advance one rising edge; leaves time 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic pat_up   [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic pat_down [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic seen_busy;
        model_reset();
        a_raw = 1'b1;
        b_raw = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // ---- 1: reset value and release with raw held high ----
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_a", a, 0);
            check("rst_b", b, 0);
            check("rst_busy", busy, 0);
`ifdef DEBOUNCE_EDGE_EN
            check("rst_a_rise", a_rise, 0);
`endif
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rel_a", a, 32'(i >= 5));
            check("rel_b", b, 32'(i >= 5));
            check("rel_busy", busy, 32'(i >= 2 && i <= 4));
        end

        // back to a clean all-low state
        rst_n = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("clean_a", a, 0);

        // ---- 2: clean step on A (edge N = first tick) ----
        a_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("step_a", a, 32'(i >= 5));
            check("step_busy", busy, 32'(i >= 2 && i <= 4));
            check("step_b", b, 0);
`ifdef DEBOUNCE_EDGE_EN
            check("step_a_rise", a_rise, 32'(i == 5));
`endif
        end
        tick();
        check("step_a_hold", a, 1);
`ifdef DEBOUNCE_EDGE_EN
        check("step_a_rise_end", a_rise, 0);
`endif

        // ---- 3: glitch rejection ----
        seen_busy = 1'b0;
        a_raw = 1'b0;
        repeat (3) begin
            tick();
            seen_busy |= busy;
            check("glitch_hi_a", a, 1);
        end
        a_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_busy |= busy;
            check("glitch_hi_a", a, 1);
        end
        check("glitch_hi_busy_seen", seen_busy, 1);
        check("glitch_hi_busy_end", busy, 0);

        a_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef DEBOUNCE_EDGE_EN
            check("fall_no_rise", a_rise, 0);
`endif
        end
        check("fall_a", a, 0);

        seen_busy = 1'b0;
        a_raw = 1'b1;
        repeat (3) begin
            tick();
            seen_busy |= busy;
            check("glitch_lo_a", a, 0);
        end
        a_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_busy |= busy;
            check("glitch_lo_a", a, 0);
        end
        check("glitch_lo_busy_seen", seen_busy, 1);
        check("glitch_lo_busy_end", busy, 0);

        // ---- 4: bounce then settle, against the run-length model ----
        for (int i = 0; i < 12; i++) begin
            a_raw = pat_up[i];
            tick();
            check("bounce_up_a", a, 32'(m_out));
            // last 0->1 is applied at i=2, so a must be high from i=7 on
            check("bounce_up_hand", a, 32'(i >= 7));
        end
        for (int i = 0; i < 12; i++) begin
            a_raw = pat_down[i];
            tick();
            check("bounce_down_a", a, 32'(m_out));
            check("bounce_down_hand", a, 32'(i < 9));
        end

        // ---- 5: simultaneous channels and mid-check reset ----
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sim_a", a, 32'(i >= 5));
            check("sim_b", b, 32'(i >= 5));
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (8) tick();
        check("sim_fall_a", a, 0);
        check("sim_fall_b", b, 0);

        a_raw = 1'b1;
        b_raw = 1'b1;
        repeat (5) tick();
        check("midchk_busy", busy, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_a", a, 0);
        check("midrst_b", b, 0);
        check("midrst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_a", a, 32'(i >= 5));
            check("post_rst_b", b, 32'(i >= 5));
`ifdef DEBOUNCE_EDGE_EN
            check("post_rst_a_rise", a_rise, 32'(i == 5));
            check("post_rst_b_rise", b_rise, 32'(i == 5));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
